data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the multicycle CPU. It is the slave side of the controller's MemRead/MemWrite memory strobes.
- Supports word, halfword and byte accesses (LW/LH/LHU/LB/LBU/SW/SH/SB), with a programmable access latency and a one-cycle completion handshake.
- Sits between the datapath (ALUOut address, register B write data) and the memory-data register.

Parameters:
- ADDR_WIDTH, 10, word-index width; storage depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between request accept and completion; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemRead  in  1  read request
- MemWrite  in  1  write request
- Addr  in  32  byte address
- WriteData  in  32  store data; the sub-word store value is taken from the low bits
- Size  in  2  access size: 00 word, 01 halfword, 10 byte, 11 illegal
- SignExt  in  1  for reads, 1 = sign-extend the sub-word result, 0 = zero-extend
- ReadData  out  32  load result; holds its value until the next successful read completes
- MemReady  out  1  one-cycle completion pulse
- AddrError  out  1  one-cycle error pulse, coincident with MemReady

Behaviour:
- Reset (async, rst_n=0):
  - ReadData=0, MemReady=0, AddrError=0, FSM=IDLE, counter=0.
  - Storage array is not cleared.
  - Reset during WAIT aborts the access; no write occurs.
- FSM states and transitions:
  - IDLE -> WAIT when MemRead|MemWrite is sampled at edge E0.
  - WAIT -> DONE when the counter reaches 0.
  - DONE -> IDLE unconditionally.
  - When LATENCY=0, IDLE -> DONE directly.
- Accept:
  - At E0, latch Addr, WriteData, Size, SignExt and the op; load counter=LATENCY-1.
  - Input changes after E0 are ignored until the FSM is back in IDLE.
- Timing:
  - Access is performed at edge E0+LATENCY (storage write or ReadData update).
  - MemReady=1 in the single cycle following that edge, i.e. while in DONE.
  - Total request-to-ready latency is LATENCY+1 rising edges.
- Back-to-back: the DONE cycle never accepts a request. A request still asserted in the following IDLE cycle is accepted as a new access, so the requester must drop its strobe after seeing MemReady.
- Simultaneous MemRead and MemWrite: accepted, but the access completes with AddrError=1 and no memory or ReadData change.
- Address mapping:
  - Word index = Addr[ADDR_WIDTH+1:2]; Addr bits above ADDR_WIDTH+1 are ignored (aliasing wrap).
  - Byte lanes are little-endian: lane k = Addr[1:0] = k holds bits [8k+7:8k].
- Alignment and size checks:
  - Word requires Addr[1:0]=00; halfword requires Addr[0]=0; byte is always aligned.
  - Misalignment or Size=11 -> AddrError=1 with MemReady, no write, ReadData unchanged.
- Reads:
  - Extract the selected byte or halfword and place it in ReadData[7:0] or ReadData[15:0].
  - Upper bits are the replicated MSB when SignExt=1, otherwise 0.
  - Word reads ignore SignExt.
- Writes: only the addressed lanes change (byte: 1 lane; half: lanes 0-1 or 2-3; word: all 4). Other lanes are preserved.
- MemReady and AddrError are registered outputs; they are never high outside DONE.

Test Plan:
1. Reset, LATENCY=2; SW Addr=0x10 WriteData=0xDEADBEEF, then LW Addr=0x10 -> MemReady high exactly 3 edges after each accept; ReadData=0xDEADBEEF; AddrError=0.
2. After test 1:
   - SB Addr=0x11 WriteData=0x000000A5 -> LW 0x10 reads 0xDEADA5EF.
   - LB 0x11 SignExt=1 -> 0xFFFFFFA5.
   - LBU 0x11 -> 0x000000A5.
3. SH Addr=0x12 WriteData=0x00001234 -> LW 0x10 reads 0x1234A5EF; LH 0x12 SignExt=1 -> 0x00001234.
4. Error cases, each giving MemReady and AddrError both high for one cycle with memory and ReadData unchanged:
   - LW Addr=0x13.
   - SH Addr=0x11.
   - MemRead=MemWrite=1.
   - Size=11.
5. SW 0x20 data 0x55AA55AA, assert rst_n=0 one edge after accept, release -> LW 0x20 returns the prior contents; MemReady was never pulsed for the aborted write.
6. LATENCY=0 and ADDR_WIDTH=4:
   - LW held continuously for 4 cycles -> MemReady on cycles 1 and 3 (DONE/IDLE alternation).
   - SW Addr=0x40 then LW Addr=0x00 -> same word (aliasing).

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle CPU: word/half/byte loads and stores
// with a fixed access latency and a one-cycle MemReady/AddrError completion pulse.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        AddrError
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t                state;
  logic [3:0]            cnt;
  logic                  rd_q, wr_q, sext_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  a_rd, a_wr, a_sext;
  logic [ADDR_WIDTH+1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [1:0]            a_size;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic [31:0]           word;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic                  req, err, do_access, mem_we;
  logic [3:0]            wmask;
  logic [31:0]           wword, rvalue;
  logic                  unused_addr;

  assign unused_addr = ^Addr[31:ADDR_WIDTH+2];
  assign req = MemRead | MemWrite;

  // With zero latency the access happens on the accept edge, so it uses the live inputs.
  always_comb begin
    if (state == IDLE) begin
      a_rd    = MemRead;
      a_wr    = MemWrite;
      a_addr  = Addr[ADDR_WIDTH+1:0];
      a_wdata = WriteData;
      a_size  = Size;
      a_sext  = SignExt;
    end else begin
      a_rd    = rd_q;
      a_wr    = wr_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_size  = size_q;
      a_sext  = sext_q;
    end
  end

  assign idx      = a_addr[ADDR_WIDTH+1:2];
  assign off      = a_addr[1:0];
  assign word     = mem[idx];
  assign half_sel = off[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[{off, 3'b000} +: 8];

  assign err = (a_rd & a_wr) | (a_size == 2'b11) |
               ((a_size == 2'b00) & (off != 2'b00)) |
               ((a_size == 2'b01) & off[0]);

  assign do_access = ((state == IDLE) & req & (LATENCY == 0)) |
                     ((state == WAIT) & (cnt == '0));
  assign mem_we    = do_access & a_wr & ~a_rd & ~err;

  always_comb begin
    wmask  = '0;
    wword  = '0;
    rvalue = '0;
    case (a_size)
      2'b00: begin
        wmask  = 4'b1111;
        wword  = a_wdata;
        rvalue = word;
      end
      2'b01: begin
        wmask  = off[1] ? 4'b1100 : 4'b0011;
        wword  = {2{a_wdata[15:0]}};
        rvalue = {{16{a_sext & half_sel[15]}}, half_sel};
      end
      2'b10: begin
        wmask  = 4'b0001 << off;
        wword  = {4{a_wdata[7:0]}};
        rvalue = {{24{a_sext & byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wmask[k]) mem[idx][8*k +: 8] <= wword[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadData  <= '0;
      MemReady  <= 1'b0;
      AddrError <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      sext_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
    end else begin
      MemReady  <= 1'b0;
      AddrError <= 1'b0;
      if (do_access) begin
        MemReady  <= 1'b1;
        AddrError <= err;
        if (a_rd && !a_wr && !err) ReadData <= rvalue;
      end
      case (state)
        IDLE: begin
          if (req) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            addr_q  <= Addr[ADDR_WIDTH+1:0];
            wdata_q <= WriteData;
            size_q  <= Size;
            sext_q  <= SignExt;
            cnt     <= CNT_INIT;
            state   <= (LATENCY == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2/ADDR_WIDTH=10,
// one at LATENCY=0/ADDR_WIDTH=4, each with its own expected-response queue.
module tb_data_mem_responder;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_rd, a_wr, a_sext, a_rdy, a_err;
  logic [31:0] a_addr, a_wd, a_rdata;
  logic [1:0]  a_size;
  logic        b_rd, b_wr, b_sext, b_rdy, b_err;
  logic [31:0] b_addr, b_wd, b_rdata;
  logic [1:0]  b_size;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   total = 0;
  int   bad   = 0;

  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, X = 2'b11;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .MemRead(a_rd), .MemWrite(a_wr), .Addr(a_addr),
    .WriteData(a_wd), .Size(a_size), .SignExt(a_sext), .ReadData(a_rdata),
    .MemReady(a_rdy), .AddrError(a_err)
  );

  data_mem_responder #(.ADDR_WIDTH(4), .LATENCY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .MemRead(b_rd), .MemWrite(b_wr), .Addr(b_addr),
    .WriteData(b_wd), .Size(b_size), .SignExt(b_sext), .ReadData(b_rdata),
    .MemReady(b_rdy), .AddrError(b_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("a_err_outside_ready", {31'b0, a_err & ~a_rdy}, 32'd0);
      check("b_err_outside_ready", {31'b0, b_err & ~b_rdy}, 32'd0);
      if (a_rdy) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_ready: got ready=1 want no pending access");
        end else begin
          ea = qa.pop_front();
          check("a_rdata", a_rdata, ea.rd);
          check("a_adderr", {31'b0, a_err}, {31'b0, ea.err});
        end
      end
      if (b_rdy) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_ready: got ready=1 want no pending access");
        end else begin
          eb = qb.pop_front();
          check("b_rdata", b_rdata, eb.rd);
          check("b_adderr", {31'b0, b_err}, {31'b0, eb.err});
        end
      end
    end
  end

  task automatic op(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                    input logic [31:0] exp_rd, input logic exp_err, input string name);
    exp_t e;
    int   edges;
    e.rd  = exp_rd;
    e.err = exp_err;
    @(negedge clk);
    if (sel) begin
      qb.push_back(e);
      b_rd = rd; b_wr = wr; b_addr = addr; b_wd = wd; b_size = sz; b_sext = sx;
    end else begin
      qa.push_back(e);
      a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd; a_size = sz; a_sext = sx;
    end
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      if (edges == 0) begin
        // scramble inputs after accept; the latched request must be used
        if (sel) begin
          b_rd = 0; b_wr = 0; b_addr = ~addr; b_wd = ~wd; b_size = ~sz; b_sext = ~sx;
        end else begin
          a_rd = 0; a_wr = 0; a_addr = ~addr; a_wd = ~wd; a_size = ~sz; a_sext = ~sx;
        end
      end
      edges++;
    end while (!(sel ? b_rdy : a_rdy) && edges < 20);
    check({name, "_latency"}, edges, sel ? 32'd1 : 32'd3);
    @(posedge clk);
  endtask

  initial begin
    logic [3:0] pattern;
    rst_n = 0;
    a_rd = 0; a_wr = 0; a_addr = '0; a_wd = '0; a_size = '0; a_sext = 0;
    b_rd = 0; b_wr = 0; b_addr = '0; b_wd = '0; b_size = '0; b_sext = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_rdata", a_rdata, 32'h0);
    check("reset_a_ready", {31'b0, a_rdy}, 32'd0);
    check("reset_a_adderr", {31'b0, a_err}, 32'd0);
    check("reset_b_ready", {31'b0, b_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    op(0, 0, 1, 32'h10, 32'hDEADBEEF, W, 0, 32'h00000000, 0, "sw10");
    op(0, 1, 0, 32'h10, 32'h0,        W, 0, 32'hDEADBEEF, 0, "lw10");
    op(0, 0, 1, 32'h11, 32'h000000A5, B, 0, 32'hDEADBEEF, 0, "sb11");
    op(0, 1, 0, 32'h10, 32'h0,        W, 0, 32'hDEADA5EF, 0, "lw10_b");
    op(0, 1, 0, 32'h11, 32'h0,        B, 1, 32'hFFFFFFA5, 0, "lb11");
    op(0, 1, 0, 32'h11, 32'h0,        B, 0, 32'h000000A5, 0, "lbu11");
    op(0, 0, 1, 32'h12, 32'h00001234, H, 0, 32'h000000A5, 0, "sh12");
    op(0, 1, 0, 32'h10, 32'h0,        W, 1, 32'h1234A5EF, 0, "lw10_h");
    op(0, 1, 0, 32'h12, 32'h0,        H, 1, 32'h00001234, 0, "lh12");
    op(0, 1, 0, 32'h10, 32'h0,        H, 1, 32'hFFFFA5EF, 0, "lh10");
    op(0, 1, 0, 32'h10, 32'h0,        H, 0, 32'h0000A5EF, 0, "lhu10");
    op(0, 1, 0, 32'h13, 32'h0,        B, 1, 32'h00000012, 0, "lb13");
    op(0, 1, 0, 32'h13, 32'h0,        W, 0, 32'h00000012, 1, "err_lw13");
    op(0, 0, 1, 32'h11, 32'h0000FFFF, H, 0, 32'h00000012, 1, "err_sh11");
    op(0, 1, 1, 32'h10, 32'h0,        W, 0, 32'h00000012, 1, "err_rdwr");
    op(0, 1, 0, 32'h10, 32'h0,        X, 0, 32'h00000012, 1, "err_size3");
    op(0, 1, 0, 32'h10, 32'h0,        W, 0, 32'h1234A5EF, 0, "lw10_after_err");
    op(0, 0, 1, 32'h10, 32'hFFFFFF77, B, 0, 32'h1234A5EF, 0, "sb10");
    op(0, 1, 0, 32'h10, 32'h0,        W, 0, 32'h1234A577, 0, "lw10_sb");
    op(0, 0, 1, 32'h20, 32'h01234567, W, 0, 32'h1234A577, 0, "sw20");

    // aborted store: reset lands one edge after accept
    @(negedge clk);
    a_wr = 1; a_addr = 32'h20; a_wd = 32'h55AA55AA; a_size = W;
    @(posedge clk);
    #1;
    a_wr = 0;
    @(posedge clk);
    #1;
    rst_n = 0;
    #2;
    check("abort_rdata_cleared", a_rdata, 32'h0);
    check("abort_ready_low", {31'b0, a_rdy}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    op(0, 1, 0, 32'h20, 32'h0, W, 0, 32'h01234567, 0, "lw20_after_abort");

    op(1, 0, 1, 32'h40, 32'hCAFEF00D, W, 0, 32'h00000000, 0, "b_sw40");
    @(negedge clk);
    ea.rd = 32'hCAFEF00D; ea.err = 0;
    qb.push_back(ea);
    qb.push_back(ea);
    b_rd = 1; b_wr = 0; b_addr = 32'h0; b_size = W; b_sext = 0;
    pattern = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      pattern[i] = b_rdy;
    end
    @(negedge clk);
    b_rd = 0;
    check("b_held_pattern", {28'b0, pattern}, 32'h5);
    @(posedge clk);
    op(1, 1, 0, 32'h03, 32'h0,        B, 1, 32'hFFFFFFCA, 0, "b_lb03");
    op(1, 0, 1, 32'h42, 32'h0000BEEF, H, 0, 32'hFFFFFFCA, 0, "b_sh42");
    op(1, 1, 0, 32'h00, 32'h0,        W, 0, 32'hBEEFF00D, 0, "b_lw00");

    repeat (2) @(negedge clk);
    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no finish want finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
